layer_loader_seq: RTL and testbench
===================================

// Module: layer_loader_seq
// PURPOSE
//  Controller for one fully-connected FRDN layer. Streams NEURONS*(INPUTS+1) weight
//  words (bias at index INPUTS) from a valid/ready source into the layer's
//  write_weight/neuron_sel/weight_sel/weight_bus port, then runs inference on request:
//  pulses layer start, waits for layer done under a watchdog, and reports completion.
//  Sits between the host/DMA weight stream and the layer instance.
// PARAMETERS
//  INPUTS    400   inputs per neuron; weight_sel spans 0..INPUTS (INPUTS = bias)
//  NEURONS   15    neurons in the controlled layer
//  TIMEOUT   65535 max cycles from layer_start to layer_done before error; >=2
// PORTS
//  clk               in   1                    clock
//  rst_n             in   1                    async active-low reset
//  cfg_start         in   1                    begin weight load (pulse)
//  in_valid          in   1                    weight word valid
//  in_data           in   64                   weight word
//  in_ready          out  1                    loader accepts word
//  run               in   1                    request one inference pass (pulse)
//  layer_write_weight out 1                    weight write strobe to layer
//  layer_neuron_sel  out  $clog2(NEURONS)      target neuron
//  layer_weight_sel  out  $clog2(INPUTS+1)     target weight index
//  layer_weight_bus  out  64                   weight value
//  layer_start       out  1                    layer start pulse
//  layer_done        in   1                    layer done pulse
//  loaded            out  1                    full weight set resident
//  busy              out  1                    state != IDLE
//  run_done          out  1                    inference finished (1-cycle pulse)
//  err               out  1                    error pulse (run w/o weights, timeout)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; loaded=0. Reset mid-load or mid-run
//   abandons the operation; loaded stays 0 until a full new load completes.
//  States: IDLE, LOAD, START, WAIT, DONE.
//  IDLE: cfg_start -> LOAD, loaded<=0, nsel<=0, wsel<=0. Else run&loaded -> START.
//   Else run&!loaded -> err pulse next cycle, stay IDLE. cfg_start and run together:
//   cfg_start wins, run dropped (no err).
//  LOAD: in_ready=1 (combinational on state only). Transfer = in_valid&in_ready.
//   Per transfer: next cycle layer_write_weight=1 with bus=in_data, neuron_sel/
//   weight_sel = counters at transfer; 1-cycle registered latency, back-to-back
//   transfers give back-to-back writes. Strobe is 0 in cycles without transfer.
//   Order: wsel 0..INPUTS for neuron 0, then neuron 1, ... wsel wraps INPUTS->0 and
//   increments nsel. On transfer of (NEURONS-1, INPUTS): counters -> 0, state -> IDLE,
//   loaded<=1 same edge as final write strobe rises. cfg_start/run ignored in LOAD.
//  START: layer_start=1 for exactly one cycle; watchdog<=0; -> WAIT.
//  WAIT: watchdog increments each cycle. layer_done -> DONE. Else watchdog==TIMEOUT-1
//   -> err pulse, -> IDLE (loaded kept). layer_done in the timeout cycle: done wins.
//   run/cfg_start ignored.
//  DONE: run_done=1 one cycle -> IDLE. A run arriving in DONE is dropped.
//  busy = (state != IDLE). layer_write_weight and layer_start never both 1.
//  Widths: counters sized exactly to select ports; no overflow beyond listed wraps.
// TESTING (bench uses INPUTS=3, NEURONS=2, TIMEOUT=8; 8 words per load)
//  Load, in_valid held high, data 1..8 -> 8 consecutive strobes; (n,w,bus) =
//   (0,0,1)..(0,3,4),(1,0,5)..(1,3,8); loaded=1 after last; in_ready 0 after.
//  Load with in_valid toggling 1010... -> strobes only 1 cycle after each
//   transfer, same (n,w,bus) sequence, no duplicates/skips.
//  run before any load -> err pulse 1 cycle later, no layer_start, busy stays 0.
//  Loaded, run; layer_done 3 cycles after layer_start -> one layer_start pulse,
//   run_done pulse the cycle after done, busy back to 0.
//  Loaded, run, layer_done never -> err exactly 8 cycles after layer_start,
//   no run_done, loaded still 1.
//  rst_n low after 4 load words -> outputs 0 asynchronously; new cfg_start
//   restarts at (0,0); cfg_start+run same cycle in IDLE -> load, no err.

Source files
------------

// File: rtl/layer_loader_seq.sv
// rtl/layer_loader_seq.sv - weight loader and inference sequencer for one FRDN layer
// Streams NEURONS*(INPUTS+1) words into the layer, then runs start/done passes under a watchdog.
module layer_loader_seq #(
    parameter int INPUTS  = 400,
    parameter int NEURONS = 15,
    parameter int TIMEOUT = 65535,
    localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int WW = $clog2(INPUTS + 1),
    localparam int TW = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cfg_start,
    input  logic          i_in_valid,
    input  logic [63:0]   i_in_data,
    output logic          o_in_ready,
    input  logic          i_run,
    output logic          o_layer_write_weight,
    output logic [NW-1:0] o_layer_neuron_sel,
    output logic [WW-1:0] o_layer_weight_sel,
    output logic [63:0]   o_layer_weight_bus,
    output logic          o_layer_start,
    input  logic          i_layer_done,
    output logic          o_loaded,
    output logic          o_busy,
    output logic          o_run_done,
    output logic          o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WW-1:0] W_LAST = WW'(INPUTS);
    localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [NW-1:0] r_nsel;
    logic [WW-1:0] r_wsel;
    logic [TW-1:0] r_wd;
    logic          r_loaded;
    logic          r_we;
    logic [NW-1:0] r_nsel_out;
    logic [WW-1:0] r_wsel_out;
    logic [63:0]   r_bus;
    logic          r_err;
    logic          w_timeout;

    // Timeout error is flagged in the last watchdog cycle itself, so it lands TIMEOUT cycles after start.
    assign w_timeout = (r_state == S_WAIT) && !i_layer_done && (r_wd == T_LAST);

    assign o_in_ready           = (r_state == S_LOAD);
    assign o_layer_start        = (r_state == S_START);
    assign o_run_done           = (r_state == S_DONE);
    assign o_busy               = (r_state != S_IDLE);
    assign o_loaded             = r_loaded;
    assign o_layer_write_weight = r_we;
    assign o_layer_neuron_sel   = r_nsel_out;
    assign o_layer_weight_sel   = r_wsel_out;
    assign o_layer_weight_bus   = r_bus;
    assign o_err                = r_err | w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_nsel     <= '0;
            r_wsel     <= '0;
            r_wd       <= '0;
            r_loaded   <= 1'b0;
            r_we       <= 1'b0;
            r_nsel_out <= '0;
            r_wsel_out <= '0;
            r_bus      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        r_state  <= S_LOAD;
                        r_loaded <= 1'b0;
                        r_nsel   <= '0;
                        r_wsel   <= '0;
                    end else if (i_run) begin
                        if (r_loaded) r_state <= S_START;
                        else          r_err   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        r_we       <= 1'b1;
                        r_bus      <= i_in_data;
                        r_nsel_out <= r_nsel;
                        r_wsel_out <= r_wsel;
                        if (r_wsel == W_LAST) begin
                            r_wsel <= '0;
                            if (r_nsel == N_LAST) begin
                                r_nsel   <= '0;
                                r_state  <= S_IDLE;
                                r_loaded <= 1'b1;
                            end else begin
                                r_nsel <= r_nsel + 1'b1;
                            end
                        end else begin
                            r_wsel <= r_wsel + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_layer_done)         r_state <= S_DONE;
                    else if (r_wd == T_LAST)  r_state <= S_IDLE;
                    else                      r_wd    <= r_wd + 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_loader_seq.sv
// tb/tb_layer_loader_seq.sv - scoreboard bench for layer_loader_seq
module tb_layer_loader_seq;

    localparam int K_WR = 0;
    localparam int K_ST = 1;
    localparam int K_RD = 2;
    localparam int K_ER = 3;

    typedef struct {
        int          kind;
        int          n;
        int          w;
        logic [63:0] bus;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        run = 1'b0;
    logic        wr;
    logic [0:0]  nsel;
    logic [1:0]  wsel;
    logic [63:0] bus;
    logic        lstart;
    logic        ldone = 1'b0;
    logic        loaded;
    logic        busy;
    logic        run_done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;
    ev_t q[$];

    layer_loader_seq #(.INPUTS(3), .NEURONS(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_start(cfg_start), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(in_ready), .i_run(run),
        .o_layer_write_weight(wr), .o_layer_neuron_sel(nsel),
        .o_layer_weight_sel(wsel), .o_layer_weight_bus(bus),
        .o_layer_start(lstart), .i_layer_done(ldone),
        .o_loaded(loaded), .o_busy(busy), .o_run_done(run_done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int n, input int w, input logic [63:0] b);
        ev_t e;
        e.kind = kind; e.n = n; e.w = w; e.bus = b;
        q.push_back(e);
    endtask

    task automatic push_load(input int base);
        for (int k = 0; k < 8; k++) push(K_WR, k / 4, k % 4, 64'(base + k));
    endtask

    task automatic match(input int kind, input int n, input int w, input logic [63:0] b);
        ev_t e;
        n_total++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d n=%0d w=%0d bus=%0h expected none", kind, n, w, b);
        end else begin
            e = q.pop_front();
            if (e.kind == kind && e.n == n && e.w == w && e.bus == b) n_pass++;
            else $display("FAIL event: got kind=%0d n=%0d w=%0d bus=%0h expected kind=%0d n=%0d w=%0d bus=%0h",
                          kind, n, w, b, e.kind, e.n, e.w, e.bus);
        end
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr)       match(K_WR, int'(nsel), int'(wsel), bus);
            if (lstart)   match(K_ST, 0, 0, 64'd0);
            if (run_done) match(K_RD, 0, 0, 64'd0);
            if (err)      match(K_ER, 0, 0, 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr", wr, 0);
        chk("rst_err", err, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // run without weights
        push(K_ER, 0, 0, 0);
        run = 1'b1; tick(); run = 1'b0;
        chk("noload_err", err, 1);
        chk("noload_busy", busy, 0);
        chk("noload_start", lstart, 0);
        tick();
        chk("noload_err_clear", err, 0);

        // burst load
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("load_ready", in_ready, 1);
        push_load(1);
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = 64'(k);
            tick();
            chk("burst_strobe", wr, 1);
        end
        in_valid = 1'b0;
        chk("burst_loaded", loaded, 1);
        chk("burst_ready_off", in_ready, 0);
        tick();
        chk("burst_strobe_off", wr, 0);

        // toggling valid load
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("reload_clears_loaded", loaded, 0);
        push_load(1);
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = in_valid ? 64'(i / 2 + 1) : 64'hdead;
            tick();
            chk("toggle_strobe", wr, in_valid);
        end
        in_valid = 1'b0;
        chk("toggle_loaded", loaded, 1);

        // run with done 3 cycles after start
        push(K_ST, 0, 0, 0);
        run = 1'b1; tick(); run = 1'b0;
        chk("run_start", lstart, 1);
        chk("run_busy", busy, 1);
        tick();
        chk("run_start_single", lstart, 0);
        tick(); tick();
        push(K_RD, 0, 0, 0);
        ldone = 1'b1; tick(); ldone = 1'b0;
        chk("run_done", run_done, 1);
        tick();
        chk("run_done_clear", run_done, 0);
        chk("run_idle", busy, 0);

        // watchdog timeout
        push(K_ST, 0, 0, 0);
        push(K_ER, 0, 0, 0);
        run = 1'b1; tick(); run = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_err_early", err, 0);
        tick();
        chk("to_err", err, 1);
        tick();
        chk("to_err_clear", err, 0);
        chk("to_idle", busy, 0);
        chk("to_loaded_kept", loaded, 1);

        // reset mid-load
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) push(K_WR, 0, k, 64'(21 + k));
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 64'(21 + k);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk("arst_wr", wr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_loaded", loaded, 0);
        #1 rst_n = 1'b1;

        // cfg_start and run together: load wins, no error
        cfg_start = 1'b1; run = 1'b1; tick(); cfg_start = 1'b0; run = 1'b0;
        chk("both_ready", in_ready, 1);
        chk("both_err", err, 0);
        push_load(11);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 64'(11 + k);
            tick();
        end
        in_valid = 1'b0;
        chk("relaod_loaded", loaded, 1);
        tick(); tick();
        chk("queue_drained", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
